// File: rtl/if_fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch front end.
package if_fetch_unit_pkg;

    // Width of one instruction word returned by instruction memory.
    localparam int INST_WIDTH = 32;

    // Byte distance between consecutive sequential fetches.
    localparam int PC_INCR = 4;

    // Architectural boot address used when no override is given.
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

    // What the fetch unit does with a memory response in the current cycle.
    typedef enum logic [1:0] {
        RSP_IGNORE = 2'd0,  // no response, or a response with nothing outstanding
        RSP_FILL   = 2'd1,  // response belongs to a live slot and is written into the ring
        RSP_DROP   = 2'd2   // response belongs to a fetch squashed by an earlier redirect
    } rsp_action_e;

endpackage

// File: rtl/if_fetch_unit_ring.sv
// DEPTH-slot response ring for the fetch unit.
// Slots are allocated in request order, filled in response order and
// drained in program order; the three pointers carry one extra wrap bit so
// that a completely full ring is distinguishable from an empty one.
module fetch_ring
    import if_fetch_unit_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int PC_WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     alloc_en,
    input  logic [PC_WIDTH-1:0]      alloc_pc,
    input  logic                     fill_en,
    input  logic [INST_WIDTH-1:0]    fill_inst,
    input  logic                     fill_err,
    input  logic                     deq_en,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [$clog2(DEPTH):0]   outstanding,
    output logic                     head_valid,
    output logic [PC_WIDTH-1:0]      head_pc,
    output logic [INST_WIDTH-1:0]    head_inst,
    output logic                     head_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [PTR_W-1:0]      alloc_ptr;
    logic [PTR_W-1:0]      fill_ptr;
    logic [PTR_W-1:0]      head_ptr;

    logic [IDX_W-1:0]      alloc_idx;
    logic [IDX_W-1:0]      fill_idx;
    logic [IDX_W-1:0]      head_idx;

    logic [PC_WIDTH-1:0]   slot_pc   [DEPTH];
    logic [INST_WIDTH-1:0] slot_inst [DEPTH];
    logic                  slot_err  [DEPTH];
    logic [DEPTH-1:0]      slot_filled;

    assign alloc_idx = alloc_ptr[IDX_W-1:0];
    assign fill_idx  = fill_ptr[IDX_W-1:0];
    assign head_idx  = head_ptr[IDX_W-1:0];

    // Pointer advance; a flush empties the ring regardless of other activity.
    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
        end else if (flush) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
        end else begin
            if (alloc_en) alloc_ptr <= alloc_ptr + PTR_ONE;
            if (fill_en)  fill_ptr  <= fill_ptr + PTR_ONE;
            if (deq_en)   head_ptr  <= head_ptr + PTR_ONE;
        end
    end

    // Per-slot filled flags: cleared on allocation and dequeue, set on fill.
    // The three indices never coincide while their enables are active.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_filled <= '0;
        end else if (flush) begin
            slot_filled <= '0;
        end else begin
            if (alloc_en) slot_filled[alloc_idx] <= 1'b0;
            if (fill_en)  slot_filled[fill_idx]  <= 1'b1;
            if (deq_en)   slot_filled[head_idx]  <= 1'b0;
        end
    end

    // Slot payload capture: PC at allocation, instruction and fault at fill.
    // NOTE: the payload arrays carry no reset; a slot's contents are only
    // observed once its filled flag is set, and that flag is reset above.
    always_ff @(posedge clk) begin
        if (alloc_en && !flush) begin
            slot_pc[alloc_idx] <= alloc_pc;
        end
        if (fill_en && !flush) begin
            slot_inst[fill_idx] <= fill_inst;
            slot_err[fill_idx]  <= fill_err;
        end
    end

    // Pointer differences and the head slot view presented to the fetch control.
    always_comb begin
        occupancy   = alloc_ptr - head_ptr;
        outstanding = alloc_ptr - fill_ptr;
        head_valid  = slot_filled[head_idx] && (head_ptr != alloc_ptr);
        head_pc     = slot_pc[head_idx];
        head_inst   = slot_inst[head_idx];
        head_err    = slot_err[head_idx];
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch front end.
// Owns the fetch PC, issues in-order requests to instruction memory, keeps
// responses in a small ring and presents {pc, inst, err} downstream with
// valid/ready handshaking. A redirect flushes the ring and converts every
// still-outstanding memory response into a drop credit so that stale
// instructions are silently discarded when they eventually return.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int                  PC_WIDTH = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC = DEFAULT_RESET_PC[PC_WIDTH-1:0],
    parameter int                  DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [PC_WIDTH-1:0]   imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [INST_WIDTH-1:0] imem_rsp_data,
    input  logic                  imem_rsp_err,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PC_WIDTH-1:0]   out_pc,
    output logic [INST_WIDTH-1:0] out_inst,
    output logic                  out_err
);

    localparam int PTR_W = $clog2(DEPTH) + 1;
    localparam logic [PTR_W-1:0]    PTR_ONE      = PTR_W'(1);
    localparam logic [PTR_W:0]      CREDIT_LIMIT = (PTR_W + 1)'(DEPTH);
    localparam logic [PC_WIDTH-1:0] PC_STEP      = PC_WIDTH'(PC_INCR);

    logic [PC_WIDTH-1:0]   fetch_pc;
    logic [PC_WIDTH-1:0]   fetch_pc_next;
    logic [PTR_W-1:0]      drop_cnt;
    logic [PTR_W-1:0]      drop_cnt_next;

    logic [PTR_W-1:0]      occupancy;
    logic [PTR_W-1:0]      outstanding;
    logic [PTR_W:0]        credit_used;
    logic                  head_valid;
    logic [PC_WIDTH-1:0]   head_pc;
    logic [INST_WIDTH-1:0] head_inst;
    logic                  head_err;

    rsp_action_e           rsp_action;
    logic                  req_fire;
    logic                  fill_en;
    logic                  deq_en;

    fetch_ring #(
        .DEPTH    (DEPTH),
        .PC_WIDTH (PC_WIDTH)
    ) u_ring (
        .clk         (clk),
        .rst         (rst),
        .flush       (redirect_valid),
        .alloc_en    (req_fire),
        .alloc_pc    (fetch_pc),
        .fill_en     (fill_en),
        .fill_inst   (imem_rsp_data),
        .fill_err    (imem_rsp_err),
        .deq_en      (deq_en),
        .occupancy   (occupancy),
        .outstanding (outstanding),
        .head_valid  (head_valid),
        .head_pc     (head_pc),
        .head_inst   (head_inst),
        .head_err    (head_err)
    );

    // Classify this cycle's memory response: squashed fetches are drained
    // first; a response with nothing outstanding is a protocol error and ignored.
    // NOTE: combinational blocks assign a default first so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        rsp_action = RSP_IGNORE;
        if (imem_rsp_valid) begin
            if (drop_cnt != '0) begin
                rsp_action = RSP_DROP;
            end else if (outstanding != '0) begin
                rsp_action = RSP_FILL;
            end
        end
    end

    // Request issue: one credit per ring slot, shared by live and squashed fetches.
    always_comb begin
        credit_used    = {1'b0, occupancy} + {1'b0, drop_cnt};
        imem_req_valid = !rst && !redirect_valid && (credit_used < CREDIT_LIMIT);
        imem_req_addr  = fetch_pc;
        req_fire       = imem_req_valid && imem_req_ready;
        fill_en        = (rsp_action == RSP_FILL) && !redirect_valid;
    end

    // Downstream presentation; payload is forced to zero whenever not valid.
    always_comb begin
        out_valid = head_valid && !redirect_valid;
        deq_en    = out_valid && out_ready;
        out_pc    = out_valid ? head_pc   : '0;
        out_inst  = out_valid ? head_inst : '0;
        out_err   = out_valid ? head_err  : 1'b0;
    end

    // Next fetch PC: redirect target (word aligned) wins over sequential advance.
    always_comb begin
        fetch_pc_next = fetch_pc;
        if (redirect_valid) begin
            fetch_pc_next = {redirect_pc[PC_WIDTH-1:2], 2'b00};
        end else if (req_fire) begin
            fetch_pc_next = fetch_pc + PC_STEP;
        end
    end

    // Next drop count: consume one credit per discarded response; on redirect,
    // every fetch still awaiting data becomes a drop credit, except one whose
    // data is arriving right now, which is simply not written.
    // NOTE: blocking assignments inside always_comb build the value step by
    // step within the same evaluation; they are never used for flops.
    always_comb begin
        drop_cnt_next = drop_cnt;
        if (rsp_action == RSP_DROP) begin
            drop_cnt_next = drop_cnt_next - PTR_ONE;
        end
        if (redirect_valid) begin
            drop_cnt_next = drop_cnt_next + outstanding;
            if (rsp_action == RSP_FILL) begin
                drop_cnt_next = drop_cnt_next - PTR_ONE;
            end
        end
    end

    // Fetch PC and drop credit registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            drop_cnt <= '0;
        end else begin
            fetch_pc <= fetch_pc_next;
            drop_cnt <= drop_cnt_next;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: an in-order memory model with
// programmable latency feeds the DUT, an expected-instruction queue is
// filled as requests are accepted and drained as the DUT delivers output.
module tb_if_fetch_unit;

    localparam int DEPTH = 4;
    localparam logic [63:0] BOOT_PC = 64'h0000_0000_8000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    logic        out_err;

    if_fetch_unit #(
        .PC_WIDTH (64),
        .RESET_PC (BOOT_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_err        (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        int          due;
        int          epoch;
    } mem_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        err;
    } exp_t;

    mem_t        mem_q[$];
    exp_t        exp_q[$];
    int          cyc;
    int          epoch;
    int          buffered;
    int          lat;
    int          n_req_obs;
    int          n_cmp;
    int          n_bad;
    logic [63:0] exp_fetch_pc;
    logic [63:0] err_addr;

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h1357_9bdf;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Assert reset (possibly mid-cycle), check outputs before any clock edge,
    // clear the model, hold for two falling edges and release.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_req_addr",  imem_req_addr, BOOT_PC);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_pc",    out_pc, 64'd0);
        chk("rst_out_inst",  64'(out_inst), 64'd0);
        chk("rst_out_err",   64'(out_err), 64'd0);
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_rsp_err   = 1'b0;
        mem_q.delete();
        exp_q.delete();
        buffered     = 0;
        epoch++;
        exp_fetch_pc = BOOT_PC;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock cycle, entered and left just after a falling edge.
    task automatic step(input logic redir, input logic [63:0] rpc,
                        input logic ordy, input logic qrdy);
        int   pend_start;
        int   buf_start;
        bit   exp_rv;
        bit   exp_ov;
        bit   live;
        mem_t m;
        exp_t e;
        redirect_valid = redir;
        redirect_pc    = rpc;
        out_ready      = ordy;
        imem_req_ready = qrdy;
        pend_start     = mem_q.size();
        buf_start      = buffered;
        live           = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_rsp_err   = 1'b0;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            m = mem_q.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = inst_of(m.addr);
            imem_rsp_err   = (m.addr == err_addr);
            live           = (m.epoch == epoch);
        end
        #1;
        exp_rv = !redir && (pend_start + buf_start < DEPTH);
        exp_ov = !redir && (buf_start > 0);
        chk("req_valid", 64'(imem_req_valid), 64'(exp_rv));
        chk("out_valid", 64'(out_valid), 64'(exp_ov));
        if (imem_req_valid && imem_req_ready) n_req_obs++;
        if (exp_ov) begin
            if (exp_q.size() > 0) begin
                e = exp_q[0];
                chk("out_pc",   out_pc, e.pc);
                chk("out_inst", 64'(out_inst), 64'(e.inst));
                chk("out_err",  64'(out_err), 64'(e.err));
                if (ordy) begin
                    void'(exp_q.pop_front());
                    buffered--;
                end
            end
        end else begin
            chk("idle_out_pc",   out_pc, 64'd0);
            chk("idle_out_inst", 64'(out_inst), 64'd0);
            chk("idle_out_err",  64'(out_err), 64'd0);
        end
        if (exp_rv && qrdy) begin
            chk("req_addr", imem_req_addr, exp_fetch_pc);
            mem_q.push_back('{exp_fetch_pc, cyc + lat, epoch});
            exp_q.push_back('{exp_fetch_pc, inst_of(exp_fetch_pc), exp_fetch_pc == err_addr});
            exp_fetch_pc += 64'd4;
        end
        if (live && !redir) buffered++;
        if (redir) begin
            exp_q.delete();
            buffered     = 0;
            epoch++;
            exp_fetch_pc = {rpc[63:2], 2'b00};
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n, input logic ordy, input logic qrdy);
        for (int i = 0; i < n; i++) step(1'b0, 64'd0, ordy, qrdy);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_rsp_err   = 1'b0;
        cyc = 0; epoch = 0; buffered = 0; lat = 1; n_req_obs = 0;
        n_cmp = 0; n_bad = 0;
        err_addr     = '1;
        exp_fetch_pc = BOOT_PC;

        // Reset state, then streaming with single-cycle memory.
        @(negedge clk);
        do_reset();
        run(12, 1'b1, 1'b1);
        run(3, 1'b1, 1'b0);
        run(6, 1'b1, 1'b1);

        // Downstream stall from an empty ring: exactly DEPTH requests, then drain.
        do_reset();
        n0 = n_req_obs;
        run(10, 1'b0, 1'b1);
        chk("stall_req_count", 64'(n_req_obs - n0), 64'(DEPTH));
        run(12, 1'b1, 1'b1);

        // Three-cycle memory, redirect to a misaligned target with fetches in flight.
        do_reset();
        lat = 3;
        run(10, 1'b1, 1'b1);
        step(1'b1, 64'h0000_0000_8000_1002, 1'b1, 1'b1);
        run(16, 1'b1, 1'b1);

        // Redirect while a response arrives and the head is being accepted.
        do_reset();
        lat = 1;
        run(6, 1'b1, 1'b1);
        step(1'b1, 64'h0000_0000_8000_2000, 1'b1, 1'b1);
        run(8, 1'b1, 1'b1);

        // Back-to-back redirects with two-cycle memory; the last one wins.
        lat = 2;
        run(6, 1'b1, 1'b1);
        step(1'b1, 64'h0000_0000_8000_3000, 1'b1, 1'b1);
        step(1'b1, 64'h0000_0000_8000_4006, 1'b1, 1'b1);
        run(12, 1'b1, 1'b1);

        // Fetch PC wraps past the top of the address space.
        step(1'b1, 64'hffff_ffff_ffff_fff9, 1'b1, 1'b1);
        run(10, 1'b1, 1'b1);

        // Access fault on the second fetch only.
        do_reset();
        lat = 1;
        err_addr = 64'h0000_0000_8000_0004;
        run(10, 1'b1, 1'b1);
        err_addr = '1;
        run(4, 1'b1, 1'b1);

        // Asynchronous reset with a full ring, then clean restart.
        do_reset();
        run(6, 1'b0, 1'b1);
        chk("full_out_valid", 64'(out_valid), 64'd1);
        chk("full_out_pc",    out_pc, BOOT_PC);
        #2;
        do_reset();
        run(10, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction fetch front end: owns the fetch PC, issues in-order requests to instruction memory over a valid/ready channel, and buffers responses in a small slot ring.
- Presents {pc, inst, err} to if_id_regs with valid/ready back-pressure.
- Sits directly upstream of if_id_regs. Accepts redirects (taken branch/jump/jalr next_pc) from ex_stage.

Parameters:
RESET_PC, 64'h0000_0000_8000_0000, fetch PC after reset
DEPTH, 4, ring slots (power of 2, >=2); bounds total outstanding fetches
PC_WIDTH, 64, PC/address width

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  PC_WIDTH  fetch address (= fetch_pc)
imem_rsp_valid  in  1  response valid, strictly in request order, no back-pressure
imem_rsp_data  in  32  instruction word
imem_rsp_err  in  1  access fault for this response
redirect_valid  in  1  flush and restart fetch
redirect_pc  in  PC_WIDTH  new fetch PC
out_valid  out  1  instruction available
out_ready  in  1  downstream accepts (stall when 0)
out_pc  out  PC_WIDTH  PC of presented instruction
out_inst  out  32  instruction
out_err  out  1  fetch fault flag

Behaviour:
- State: fetch_pc; ring of DEPTH slots {pc, inst, err, filled}; pointers alloc, fill, head (log2(DEPTH)+1 bits, wrap naturally); drop_cnt (log2(DEPTH)+1 bits).
- Reset (async, any time, including mid-transaction): fetch_pc=RESET_PC; pointers=0; drop_cnt=0; all filled=0; imem_req_valid=0, out_valid=0, out_pc=0, out_inst=0, out_err=0. In-flight memory responses are the memory model's responsibility to squash on rst.
- occupancy = alloc-head. Request: imem_req_valid = !redirect_valid && (occupancy+drop_cnt < DEPTH); imem_req_addr=fetch_pc.
- Accept (valid&ready): slot[alloc].pc=fetch_pc, filled=0; alloc++; fetch_pc+=4 (mod 2^PC_WIDTH, wraps silently).
- Response: if drop_cnt>0, discard and drop_cnt--. Else write inst/err into slot[fill], filled=1, fill++. rsp_valid while fill==alloc and drop_cnt==0 is a protocol error: ignore it; bench asserts this never occurs.
- Output: out_valid = slot[head].filled && (head!=alloc) && !redirect_valid. out_* driven from slot[head]; all zero when out_valid=0. Dequeue on out_valid&out_ready: head++, clear filled.
- No response bypass: response at cycle N+1 appears on out_* at N+2. A slot lives 3 cycles, so DEPTH>=3 is required for 1 inst/cycle with single-cycle memory.
- Redirect (priority over everything except rst), next state:
  - fetch_pc = {redirect_pc[PC_WIDTH-1:2],2'b00};
  - alloc=fill=head=0; all filled=0;
  - drop_cnt = drop_cnt + (alloc-fill) - (rsp_valid && drop_cnt==0 && fill!=alloc ? 1 : 0) - (rsp_valid && drop_cnt>0 ? 1 : 0). Net effect: every outstanding response, including one arriving that cycle, is discarded exactly once.
  - The request is withdrawn that cycle (memory permits withdrawal); out_ready is ignored.
  - First request at new PC: cycle after redirect, subject to the drop_cnt credit.
- Back-to-back redirects: each applies; the last one wins fetch_pc, and drop_cnt accumulates correctly.
- Full ring (occupancy+drop_cnt==DEPTH): imem_req_valid=0 until a dequeue or drop frees credit (takes effect the next cycle).
- err responses are queued normally. No special halt; downstream decides.

Decomposition:
- Shared defines header (existing rvseed_defines.v): RESET_PC value, INST_WIDTH=32, PC increment 4.
- One sub-module: fetch_ring (DEPTH-slot storage with alloc/fill/head pointers, occupancy and head-filled outputs). if_fetch_unit holds fetch_pc, drop_cnt, request/redirect control.

Test Plan:
- Reset then req_ready=1, 1-cycle memory returning addr-derived words, out_ready=1 -> first request at 0x80000000 in the first cycle after rst falls; out_pc 0x80000000, 0x80000004, 0x80000008... one per cycle from the third cycle on; no gaps.
- out_ready=0 for 10 cycles -> exactly DEPTH=4 requests issued (0x80000000-0x8000000C), imem_req_valid low thereafter. On release, the 4 instructions drain in order and requests resume at 0x80000010.
- Memory latency 3 cycles, redirect_pc=0x80001002 with 2 responses outstanding -> both late responses discarded. Next request addr 0x80001000, issued only once credit allows. out_pc never shows stale PCs.
- Redirect in the same cycle as rsp_valid, out_valid and out_ready -> no dequeue counted downstream, arriving response dropped, drop_cnt equals prior outstanding minus 1; next output is the redirect target.
- imem_rsp_err=1 on the 2nd fetch -> out_err=1 only with out_pc=0x80000004, inst passes through unchanged.
- rst asserted mid-stream with full ring -> all outputs 0 immediately (asynchronous, before the next clk edge); after release, fetch restarts at 0x80000000 with empty ring.
